rgb_process_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational RGB pixel processor in the D8M camera-to-VGA path. Sits between the camera pixel stream (after Bayer-to-RGB) and the VGA output. Per pixel it applies, in priority order: crop blanking, corner calibration markers, a two-segment contrast curve, and per-channel attenuation. Control inputs are latched only at start-of-frame, so switch changes never tear a frame.

---
 rtl/rgb_process_pkg.sv | 21 ++
 rtl/rgb_tone_ch.sv | 85 ++++++++
 rtl/rgb_process_pipe.sv | 160 ++++++++++++++++
 tb/tb_rgb_process_pipe.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rgb_process_pkg.sv
// rgb_process_pkg: shared types and constants for rgb_process_pipe.
//   level_t          intensity level (attenuation select / contrast table index)
//   GAIN_SHIFT       right shift applied to raw*gain products
//   GAIN_W           width of a gain coefficient
//   LO_GAIN/HI_GAIN  contrast-curve gains below / at-or-above the pivot, indexed by level
package rgb_process_pkg;

  typedef enum logic [1:0] {
    LVL_OFF  = 2'd0,
    LVL_QTR  = 2'd1,
    LVL_HALF = 2'd2,
    LVL_FULL = 2'd3
  } level_t;

  localparam int GAIN_SHIFT = 4;
  localparam int GAIN_W     = 5;

  localparam logic [GAIN_W-1:0] LO_GAIN [4] = '{5'd6, 5'd4, 5'd3, 5'd1};
  localparam logic [GAIN_W-1:0] HI_GAIN [4] = '{5'd18, 5'd20, 5'd21, 5'd23};

endpackage

// File: rtl/rgb_tone_ch.sv
// rgb_tone_ch: one colour channel of rgb_process_pipe.
//   Stage 1 registers the raw value and both contrast products.
//   Stage 2 applies shift, saturation, and the override/curve/attenuation mux.
// Ports:
//   clk, rst     pixel clock, asynchronous active-high reset
//   load         stage-1 capture enable (input pixel valid)
//   raw          raw channel value
//   gain_lvl     level used to pick the stage-1 gains (effective level of this pixel)
//   s1_valid     stage-1 contents valid; output forced to 0 when low
//   br           contrast-curve mode for the stage-1 pixel
//   att_lvl      attenuation level for the stage-1 pixel
//   en           attenuation enable for the stage-1 pixel
//   force_zero   blank this channel (crop or another channel's marker)
//   force_max    drive this channel to full scale (own marker)
//   data         processed channel value (registered)
module rgb_tone_ch
  import rgb_process_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MID    = 1 << (DATA_W - 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] raw,
  input  level_t            gain_lvl,
  input  logic              s1_valid,
  input  logic              br,
  input  level_t            att_lvl,
  input  logic              en,
  input  logic              force_zero,
  input  logic              force_max,
  output logic [DATA_W-1:0] data
);

  localparam int                PW    = DATA_W + GAIN_W;
  localparam logic [PW-1:0]     SAT   = PW'((1 << DATA_W) - 1);
  localparam logic [DATA_W-1:0] MAXV  = '1;
  localparam logic [DATA_W-1:0] MID_V = DATA_W'(MID);

  logic [DATA_W-1:0] raw_q;
  logic [PW-1:0]     prod_lo_q, prod_hi_q;
  logic [PW-1:0]     lo_sh, hi_sh;
  logic [DATA_W-1:0] curve, att, sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q     <= '0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
    end else if (load) begin
      raw_q     <= raw;
      prod_lo_q <= PW'(raw) * PW'(LO_GAIN[gain_lvl]);
      prod_hi_q <= PW'(raw) * PW'(HI_GAIN[gain_lvl]);
    end
  end

  always_comb begin
    lo_sh = prod_lo_q >> GAIN_SHIFT;
    hi_sh = prod_hi_q >> GAIN_SHIFT;
    // Saturation is judged on the full-width shifted product, before truncation.
    if (raw_q < MID_V)      curve = lo_sh[DATA_W-1:0];
    else if (hi_sh > SAT)   curve = MAXV;
    else                    curve = hi_sh[DATA_W-1:0];

    case (att_lvl)
      LVL_OFF:  att = '0;
      LVL_QTR:  att = raw_q >> 2;
      LVL_HALF: att = raw_q >> 1;
      default:  att = raw_q;
    endcase

    if (force_zero)     sel = '0;
    else if (force_max) sel = MAXV;
    else if (br)        sel = curve;
    else if (en)        sel = att;
    else                sel = raw_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data <= '0;
    else     data <= s1_valid ? sel : '0;
  end

endmodule

// File: rtl/rgb_process_pipe.sv
// rgb_process_pipe: two-stage RGB pixel processor (crop blank, corner markers,
// contrast curve, per-channel attenuation). Control is sampled at start of frame.
// Optional feature macro: RGB_PROC_MARKER_EN (corner calibration markers).
// Ports:
//   clk, rst          pixel clock, asynchronous active-high reset
//   in_valid, in_sof  pixel present / first pixel of frame (sof qualified by valid)
//   in_row, in_col    pixel coordinates
//   in_data           pixel, channel k at [k*DATA_W +: DATA_W]
//   level, ch_en, bright_en  frame controls, captured on a valid sof
//   out_valid, out_row, out_col, out_data  processed pixel, 2 cycles after input
// Handshake: valid-only stream, no ready. Every cycle with in_valid=1 carries one
// pixel; exactly two cycles later out_valid=1 with that pixel. Gaps pass through
// as bubbles, and out_data is 0 whenever out_valid=0.
module rgb_process_pipe
  import rgb_process_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3,
  parameter int CROP_W = 617,
  parameter int CROP_H = 478,
  parameter int MARK   = 5,
  parameter int MID    = 1 << (DATA_W - 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [12:0]              in_row,
  input  logic [12:0]              in_col,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [1:0]               level,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     bright_en,
  output logic                     out_valid,
  output logic [12:0]              out_row,
  output logic [12:0]              out_col,
  output logic [NUM_CH*DATA_W-1:0] out_data
);

  localparam int          NMARK  = 3;
  localparam logic [12:0] CROP_WV = 13'(CROP_W);
  localparam logic [12:0] CROP_HV = 13'(CROP_H);

  // Frame shadows and the effective controls for the current input pixel:
  // a sof pixel already uses the values presented with it.
  level_t              lvl_q, lvl_eff;
  logic [NUM_CH-1:0]   en_q, en_eff;
  logic                br_q, br_eff;
  logic                sof_hit;

  logic                blank_d;
  logic [NMARK-1:0]    mark_d;

  logic                v_s1, br_s1, blank_s1;
  level_t              lvl_s1;
  logic [NUM_CH-1:0]   en_s1;
  logic [NMARK-1:0]    mark_s1;
  logic [12:0]         row_s1, col_s1;

  assign sof_hit = in_valid && in_sof;
  assign lvl_eff = sof_hit ? level_t'(level) : lvl_q;
  assign en_eff  = sof_hit ? ch_en : en_q;
  assign br_eff  = sof_hit ? bright_en : br_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= LVL_OFF;
      en_q  <= '0;
      br_q  <= 1'b0;
    end else if (sof_hit) begin
      lvl_q <= level_t'(level);
      en_q  <= ch_en;
      br_q  <= bright_en;
    end
  end

  assign blank_d = (in_row >= CROP_HV) || (in_col >= CROP_WV);

`ifdef RGB_PROC_MARKER_EN
  localparam logic [12:0] MARK_V = 13'(MARK);
  localparam logic [12:0] COL_HI = 13'(CROP_W - MARK);
  localparam logic [12:0] ROW_HI = 13'(CROP_H - MARK);

  // One-hot marker hit; markers for channels that do not exist stay off.
  always_comb begin
    mark_d = '0;
    if (in_row < MARK_V && in_col < MARK_V)
      mark_d[0] = (NUM_CH > 0);
    if (in_row < MARK_V && in_col >= COL_HI && in_col < CROP_WV)
      mark_d[1] = (NUM_CH > 1);
    if (in_row >= ROW_HI && in_row < CROP_HV && in_col < MARK_V)
      mark_d[2] = (NUM_CH > 2);
  end
`else
  assign mark_d = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_s1     <= 1'b0;
      row_s1   <= '0;
      col_s1   <= '0;
      blank_s1 <= 1'b0;
      mark_s1  <= '0;
      br_s1    <= 1'b0;
      lvl_s1   <= LVL_OFF;
      en_s1    <= '0;
    end else begin
      v_s1 <= in_valid;
      if (in_valid) begin
        row_s1   <= in_row;
        col_s1   <= in_col;
        blank_s1 <= blank_d;
        mark_s1  <= mark_d;
        br_s1    <= br_eff;
        lvl_s1   <= lvl_eff;
        en_s1    <= en_eff;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      out_valid <= v_s1;
      out_row   <= row_s1;
      out_col   <= col_s1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic fmax, fzero;
    if (k < NMARK) begin : g_mk
      assign fmax = mark_s1[k];
    end else begin : g_nomk
      assign fmax = 1'b0;
    end
    // Any marker blanks every channel except the one it lights.
    assign fzero = blank_s1 || ((|mark_s1) && !fmax);

    rgb_tone_ch #(.DATA_W(DATA_W), .MID(MID)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .load       (in_valid),
      .raw        (in_data[k*DATA_W +: DATA_W]),
      .gain_lvl   (lvl_eff),
      .s1_valid   (v_s1),
      .br         (br_s1),
      .att_lvl    (lvl_s1),
      .en         (en_s1[k]),
      .force_zero (fzero),
      .force_max  (fmax),
      .data       (out_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_rgb_process_pipe.sv
// tb_rgb_process_pipe: directed self-checking bench for rgb_process_pipe
// (default parameters; marker expectations follow RGB_PROC_MARKER_EN).
module tb_rgb_process_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sof;
  logic [12:0] in_row, in_col;
  logic [23:0] in_data;
  logic [1:0]  level;
  logic [2:0]  ch_en;
  logic        bright_en;
  logic        out_valid;
  logic [12:0] out_row, out_col;
  logic [23:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  rgb_process_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_row    (in_row),
    .in_col    (in_col),
    .in_data   (in_data),
    .level     (level),
    .ch_en     (ch_en),
    .bright_en (bright_en),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_data  (out_data)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [23:0] rgb(input int r, input int g, input int b);
    rgb = {8'(b), 8'(g), 8'(r)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: one isolated pixel, then check latency, alignment and data.
  task automatic send(input string tag, input int row, input int col,
                      input logic [23:0] d, input logic sof, input logic [23:0] exp);
    in_valid = 1'b1;
    in_sof   = sof;
    in_row   = 13'(row);
    in_col   = 13'(col);
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_row"}, {19'd0, out_row}, 32'(row));
    check({tag, "_col"}, {19'd0, out_col}, 32'(col));
    check({tag, "_data"}, {8'd0, out_data}, {8'd0, exp});
  endtask

  task automatic set_ctl(input logic [1:0] l, input logic [2:0] e, input logic b);
    level = l; ch_en = e; bright_en = b;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    in_row = '0; in_col = '0; in_data = '0;
    set_ctl(2'd0, 3'b000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {8'd0, out_data}, 32'd0);
    check("rst_row", {19'd0, out_row}, 32'd0);
    check("rst_col", {19'd0, out_col}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Shadows still at reset: pass-through despite live controls.
    set_ctl(2'd0, 3'b111, 1'b1);
    send("pass", 100, 100, rgb(200, 100, 50), 1'b0, rgb(200, 100, 50));

    // Contrast curve, level 0; B=128 sits on the pivot and takes the high branch.
    set_ctl(2'd0, 3'b000, 1'b1);
    send("curve_l0", 100, 100, rgb(100, 200, 128), 1'b1, rgb(37, 225, 144));

    set_ctl(2'd3, 3'b000, 1'b1);
    send("curve_sat", 10, 20, rgb(200, 200, 200), 1'b1, rgb(255, 255, 255));
    send("curve_low", 11, 21, rgb(127, 127, 127), 1'b0, rgb(7, 7, 7));

    // Attenuation and mid-frame control change.
    set_ctl(2'd1, 3'b001, 1'b0);
    send("att_qtr", 30, 40, rgb(200, 200, 200), 1'b1, rgb(50, 200, 200));
    set_ctl(2'd2, 3'b001, 1'b0);
    send("att_hold", 31, 40, rgb(200, 200, 200), 1'b0, rgb(50, 200, 200));
    send("att_half", 0, 40, rgb(200, 200, 200), 1'b1, rgb(100, 200, 200));
    set_ctl(2'd0, 3'b110, 1'b0);
    send("att_off", 50, 60, rgb(200, 200, 200), 1'b1, rgb(200, 0, 0));

    // Regions: markers (build dependent), crop blanking, crop edges.
    set_ctl(2'd0, 3'b000, 1'b0);
`ifdef RGB_PROC_MARKER_EN
    send("mark_r", 0, 0, rgb(10, 20, 30), 1'b1, rgb(255, 0, 0));
    send("mark_g", 0, 615, rgb(10, 20, 30), 1'b0, rgb(0, 255, 0));
    send("mark_b", 475, 2, rgb(10, 20, 30), 1'b0, rgb(0, 0, 255));
`else
    send("mark_r", 0, 0, rgb(10, 20, 30), 1'b1, rgb(10, 20, 30));
    send("mark_g", 0, 615, rgb(10, 20, 30), 1'b0, rgb(10, 20, 30));
    send("mark_b", 475, 2, rgb(10, 20, 30), 1'b0, rgb(10, 20, 30));
`endif
    send("blank_row", 479, 0, rgb(10, 20, 30), 1'b0, 24'd0);
    send("blank_col", 10, 620, rgb(10, 20, 30), 1'b0, 24'd0);
    send("blank_h", 478, 100, rgb(10, 20, 30), 1'b0, 24'd0);
    send("blank_w", 100, 617, rgb(10, 20, 30), 1'b0, 24'd0);
    send("edge_in", 477, 616, rgb(10, 20, 30), 1'b0, rgb(10, 20, 30));

    // Back-to-back stream with a scoreboard queue.
    set_ctl(2'd1, 3'b010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        in_valid = 1'b1;
        in_sof   = (i == 0);
        in_row   = 13'd200;
        in_col   = 13'(200 + i);
        in_data  = rgb(16 + i * 40, 100 + i * 4, 60 - i);
        exp_q.push_back(rgb(16 + i * 40, (100 + i * 4) >> 2, 60 - i));
      end else begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end
      @(posedge clk); #1;
      if (i >= 1) begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("stream_valid", {31'd0, out_valid}, 32'd1);
        check("stream_col", {19'd0, out_col}, 32'(200 + i - 1));
        check("stream_data", {8'd0, out_data}, {8'd0, e});
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_end", {31'd0, out_valid}, 32'd0);
    check("stream_bubble_data", {8'd0, out_data}, 32'd0);

    // Reset with both stages occupied.
    set_ctl(2'd0, 3'b000, 1'b0);
    in_valid = 1'b1; in_sof = 1'b1; in_row = 13'd5; in_col = 13'd6;
    in_data = rgb(1, 2, 3);
    @(posedge clk); #1;
    in_sof = 1'b0; in_col = 13'd7; in_data = rgb(4, 5, 6);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_data", {8'd0, out_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("flush_s1", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("flush_idle", {31'd0, out_valid}, 32'd0);
    // Shadows cleared by reset: controls seen without sof are ignored.
    set_ctl(2'd0, 3'b111, 1'b1);
    send("post_rst", 7, 8, rgb(90, 180, 240), 1'b0, rgb(90, 180, 240));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
